// File: rtl/acc_datapath.sv
// -----------------------------------------------------------------------------
// acc_datapath
//   Accumulator datapath driven by the program-ROM control word. It holds the
//   register file R0..R3, the accumulator A, the carry/borrow flag CY and the
//   ALU. Every state update lands on the next rising clk edge.
//
// Ports
//   clk      in   1      single clock, rising edge
//   Reset    in   1      synchronous reset, active-high
//   RegAddr  in   4      one-hot register select, bit i = Ri
//   ALUCode  in   3      LD=000 ADD=001 SUB=010 AND=011 NOT=100 ST=101
//   Reg_CE   in   1      write A into the selected register(s)
//   CY_CE    in   1      update CY from an ADD/SUB result
//   A_CE     in   1      load the ALU result into A
//   ResetCY  in   1      clear CY at the next edge
//   A        out  WIDTH  accumulator (registered)
//   CY       out  1      carry/borrow flag (registered)
//   Zero     out  1      combinational, A == 0
//   Operand  out  WIDTH  combinational, OR of all selected registers
// -----------------------------------------------------------------------------
module acc_datapath #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  R0_INIT = 'd0,
  parameter logic [WIDTH-1:0]  R1_INIT = 'd1,
  parameter logic [WIDTH-1:0]  R2_INIT = 'd2,
  parameter logic [WIDTH-1:0]  R3_INIT = 'd4
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [3:0]        RegAddr,
  input  logic [2:0]        ALUCode,
  input  logic              Reg_CE,
  input  logic              CY_CE,
  input  logic              A_CE,
  input  logic              ResetCY,
  output logic [WIDTH-1:0]  A,
  output logic              CY,
  output logic              Zero,
  output logic [WIDTH-1:0]  Operand
);

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;

  logic [WIDTH-1:0] r_a;
  logic             r_cy;
  logic [WIDTH-1:0] r_regs [4];

  logic [WIDTH-1:0] w_operand;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_cy_next;

  // ---------------------------------------------------------------------------
  // Register file: each Ri captures the pre-edge A when selected with Reg_CE.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      localparam logic [WIDTH-1:0] INIT = (gi == 0) ? R0_INIT :
                                          (gi == 1) ? R1_INIT :
                                          (gi == 2) ? R2_INIT : R3_INIT;
      always_ff @(posedge clk) begin
        if (Reset) begin
          r_regs[gi] <= INIT;
        end else if (Reg_CE && RegAddr[gi]) begin
          r_regs[gi] <= r_a;
        end
      end
    end
  endgenerate

  // Operand is the OR of every selected register, so no select gives 0.
  always_comb begin
    w_operand = '0;
    for (int i = 0; i < 4; i++) begin
      if (RegAddr[i]) begin
        w_operand = w_operand | r_regs[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU. Both arithmetic paths are zero-extended by one bit so the top bit of
  // the result is the carry out (ADD) or the borrow out (SUB).
  // ---------------------------------------------------------------------------
  assign w_sum  = {1'b0, r_a} + {1'b0, w_operand} + {{WIDTH{1'b0}}, r_cy};
  assign w_diff = {1'b0, r_a} - {1'b0, w_operand} - {{WIDTH{1'b0}}, r_cy};

  always_comb begin
    w_result = r_a;
    case (ALUCode)
      OP_LD:   w_result = w_operand;
      OP_ADD:  w_result = w_sum[WIDTH-1:0];
      OP_SUB:  w_result = w_diff[WIDTH-1:0];
      OP_AND:  w_result = r_a & w_operand;
      OP_NOT:  w_result = ~r_a;
      OP_ST:   w_result = r_a;
      default: w_result = r_a;
    endcase
  end

  // CY: clear has priority, then ADD/SUB updates; other codes leave it alone.
  always_comb begin
    w_cy_next = r_cy;
    if (ResetCY) begin
      w_cy_next = 1'b0;
    end else if (CY_CE && (ALUCode == OP_ADD)) begin
      w_cy_next = w_sum[WIDTH];
    end else if (CY_CE && (ALUCode == OP_SUB)) begin
      w_cy_next = w_diff[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_a  <= '0;
      r_cy <= 1'b0;
    end else begin
      if (A_CE) begin
        r_a <= w_result;
      end
      r_cy <= w_cy_next;
    end
  end

  assign A       = r_a;
  assign CY      = r_cy;
  assign Zero    = (r_a == '0);
  assign Operand = w_operand;

endmodule

// File: tb/tb_acc_datapath.sv
// -----------------------------------------------------------------------------
// tb_acc_datapath
//   Directed testbench for acc_datapath. Each task sets up its own state from
//   reset, applies control words and compares A, CY, Zero and register values
//   (read back through Operand) against hand-computed values.
// -----------------------------------------------------------------------------
module tb_acc_datapath;

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_ST  = 3'b101;
  localparam logic [2:0] OP_DEF = 3'b111;

  logic       clk;
  logic       Reset;
  logic [3:0] RegAddr;
  logic [2:0] ALUCode;
  logic       Reg_CE;
  logic       CY_CE;
  logic       A_CE;
  logic       ResetCY;
  logic [7:0] A;
  logic       CY;
  logic       Zero;
  logic [7:0] Operand;

  int checks;
  int passes;

  acc_datapath dut (
    .clk     (clk),
    .Reset   (Reset),
    .RegAddr (RegAddr),
    .ALUCode (ALUCode),
    .Reg_CE  (Reg_CE),
    .CY_CE   (CY_CE),
    .A_CE    (A_CE),
    .ResetCY (ResetCY),
    .A       (A),
    .CY      (CY),
    .Zero    (Zero),
    .Operand (Operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM default word: leaves all state unchanged.
  task automatic idle_word();
    Reset   = 1'b0;
    RegAddr = 4'b1111;
    ALUCode = OP_DEF;
    Reg_CE  = 1'b0;
    CY_CE   = 1'b0;
    A_CE    = 1'b0;
    ResetCY = 1'b0;
  endtask

  // Apply one control word for one edge; outputs are stable on return.
  task automatic apply(input logic [3:0] ra, input logic [2:0] op,
                       input logic reg_ce, input logic cy_ce,
                       input logic a_ce, input logic rcy);
    RegAddr = ra;
    ALUCode = op;
    Reg_CE  = reg_ce;
    CY_CE   = cy_ce;
    A_CE    = a_ce;
    ResetCY = rcy;
    @(posedge clk);
    #1;
    idle_word();
  endtask

  task automatic do_reset();
    idle_word();
    Reset = 1'b1;
    @(posedge clk);
    #1;
    Reset = 1'b0;
  endtask

  // Read a register through Operand using an idle control word.
  task automatic read_reg(input int idx, output logic [7:0] val);
    idle_word();
    RegAddr = 4'b0001 << idx;
    @(negedge clk);
    val = Operand;
    $display("read R%0d = %02h", idx, val);
    idle_word();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h00; exp_r[1] = 8'h01; exp_r[2] = 8'h02; exp_r[3] = 8'h04;
    do_reset();
    // arbitrary traffic
    apply(4'b1000, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(4'b0011, OP_ST,  1'b1, 1'b0, 1'b0, 1'b0);
    apply(4'b0000, OP_NOT, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(4'b0100, OP_SUB, 1'b1, 1'b1, 1'b1, 1'b0);
    // reset in the middle of a program word: reset must win
    RegAddr = 4'b1111; ALUCode = OP_ADD; Reg_CE = 1'b1; CY_CE = 1'b1; A_CE = 1'b1;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    idle_word();
    $display("reset: A=%02h CY=%0b Zero=%0b", A, CY, Zero);
    checks++; if (A !== 8'h00) $display("FAIL reset_A got %02h want 00", A); else passes++;
    checks++; if (CY !== 1'b0) $display("FAIL reset_CY got %0b want 0", CY); else passes++;
    checks++; if (Zero !== 1'b1) $display("FAIL reset_Zero got %0b want 1", Zero); else passes++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== exp_r[i]) $display("FAIL reset_R%0d got %02h want %02h", i, v, exp_r[i]);
      else passes++;
    end
    // OR of all registers
    RegAddr = 4'b1111;
    @(negedge clk);
    $display("operand all = %02h", Operand);
    checks++; if (Operand !== 8'h07) $display("FAIL operand_or got %02h want 07", Operand); else passes++;
    RegAddr = 4'b0000;
    @(negedge clk);
    $display("operand none = %02h", Operand);
    checks++; if (Operand !== 8'h00) $display("FAIL operand_none got %02h want 00", Operand); else passes++;
    idle_word();
  endtask

  task automatic test_add();
    logic [7:0] exp_a [3];
    logic [3:0] sel [3];
    exp_a[0] = 8'h04; exp_a[1] = 8'h06; exp_a[2] = 8'h07;
    sel[0] = 4'b1000; sel[1] = 4'b0100; sel[2] = 4'b0010;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(sel[i], OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
      $display("add sel=%04b: A=%02h CY=%0b", sel[i], A, CY);
      checks++;
      if (A !== exp_a[i] || CY !== 1'b0)
        $display("FAIL add_%0d got A=%02h CY=%0b want A=%02h CY=0", i, A, CY, exp_a[i]);
      else passes++;
    end
  endtask

  task automatic test_sub();
    logic [7:0] exp_a [3];
    logic       exp_c [3];
    logic [3:0] sel [3];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hF9; exp_a[2] = 8'hF5;
    exp_c[0] = 1'b1;  exp_c[1] = 1'b0;  exp_c[2] = 1'b0;
    sel[0] = 4'b0100; sel[1] = 4'b1000; sel[2] = 4'b1000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(sel[i], OP_SUB, 1'b0, 1'b1, 1'b1, 1'b0);
      $display("sub sel=%04b: A=%02h CY=%0b", sel[i], A, CY);
      checks++;
      if (A !== exp_a[i] || CY !== exp_c[i])
        $display("FAIL sub_%0d got A=%02h CY=%0b want A=%02h CY=%0b",
                 i, A, CY, exp_a[i], exp_c[i]);
      else passes++;
    end
  endtask

  task automatic test_carry_wrap();
    do_reset();
    apply(4'b0000, OP_NOT, 1'b0, 1'b0, 1'b1, 1'b0);   // A = FF
    checks++; if (A !== 8'hFF) $display("FAIL not_ff got %02h want FF", A); else passes++;
    apply(4'b0010, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);   // FF+1 -> 00, CY=1
    $display("wrap add: A=%02h CY=%0b Zero=%0b", A, CY, Zero);
    checks++;
    if (A !== 8'h00 || CY !== 1'b1 || Zero !== 1'b1)
      $display("FAIL wrap_add got A=%02h CY=%0b Z=%0b want A=00 CY=1 Z=1", A, CY, Zero);
    else passes++;
    apply(4'b0001, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);   // 0+0+1 -> 01
    $display("carry-in add: A=%02h CY=%0b Zero=%0b", A, CY, Zero);
    checks++;
    if (A !== 8'h01 || CY !== 1'b0 || Zero !== 1'b0)
      $display("FAIL carry_in_add got A=%02h CY=%0b Z=%0b want A=01 CY=0 Z=0", A, CY, Zero);
    else passes++;
    // CY_CE with a non-arithmetic code leaves CY alone; first set CY again
    apply(4'b0000, OP_NOT, 1'b0, 1'b0, 1'b1, 1'b0);   // A = FE
    apply(4'b0100, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);   // FE+2 -> 00, CY=1
    apply(4'b0100, OP_LD,  1'b0, 1'b1, 1'b1, 1'b0);   // A = 02, CY holds
    $display("ld with cy_ce: A=%02h CY=%0b", A, CY);
    checks++;
    if (A !== 8'h02 || CY !== 1'b1)
      $display("FAIL ld_cy_hold got A=%02h CY=%0b want A=02 CY=1", A, CY);
    else passes++;
  endtask

  task automatic test_logic_store();
    logic [7:0] v;
    do_reset();
    apply(4'b1000, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(4'b0100, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(4'b0010, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);   // A = 07
    apply(4'b0010, OP_ST,  1'b1, 1'b0, 1'b0, 1'b0);   // R1 = 07
    read_reg(1, v);
    checks++; if (v !== 8'h07) $display("FAIL st_r1 got %02h want 07", v); else passes++;
    apply(4'b0000, OP_NOT, 1'b0, 1'b0, 1'b1, 1'b0);   // A = F8
    checks++; if (A !== 8'hF8) $display("FAIL not got %02h want F8", A); else passes++;
    apply(4'b0010, OP_AND, 1'b0, 1'b0, 1'b1, 1'b0);   // F8 & 07 = 00
    checks++; if (A !== 8'h00) $display("FAIL and got %02h want 00", A); else passes++;
    apply(4'b0010, OP_LD,  1'b1, 1'b0, 1'b1, 1'b0);   // swap: R1=00, A=07
    read_reg(1, v);
    $display("swap: A=%02h R1=%02h", A, v);
    checks++;
    if (A !== 8'h07 || v !== 8'h00)
      $display("FAIL swap got A=%02h R1=%02h want A=07 R1=00", A, v);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] exp_r [4];
    exp_r[0] = 8'h00; exp_r[1] = 8'h01; exp_r[2] = 8'h02; exp_r[3] = 8'h04;
    do_reset();
    apply(4'b0000, OP_NOT, 1'b0, 1'b0, 1'b1, 1'b0);   // A = FF
    apply(4'b0010, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b0);   // A = 00, CY = 1
    apply(4'b1000, OP_ADD, 1'b0, 1'b1, 1'b1, 1'b1);   // A = 00+4+1, CY cleared
    $display("resetcy add: A=%02h CY=%0b", A, CY);
    checks++;
    if (A !== 8'h05 || CY !== 1'b0)
      $display("FAIL resetcy_add got A=%02h CY=%0b want A=05 CY=0", A, CY);
    else passes++;
    apply(4'b0000, OP_ST, 1'b1, 1'b0, 1'b0, 1'b0);    // no register selected
    // ROM default word for a few cycles: nothing may change
    for (int i = 0; i < 3; i++) apply(4'b1111, OP_DEF, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (A !== 8'h05 || CY !== 1'b0)
      $display("FAIL default_hold got A=%02h CY=%0b want A=05 CY=0", A, CY);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      checks++;
      if (v !== exp_r[i]) $display("FAIL nowrite_R%0d got %02h want %02h", i, v, exp_r[i]);
      else passes++;
    end
    // multi-select write: R0 and R2 both take A
    apply(4'b0101, OP_ST, 1'b1, 1'b0, 1'b0, 1'b0);
    RegAddr = 4'b0101;
    @(negedge clk);
    $display("multi write R0|R2 = %02h", Operand);
    checks++; if (Operand !== 8'h05) $display("FAIL multi_write got %02h want 05", Operand); else passes++;
    idle_word();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    idle_word();
    Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_add();
    test_sub();
    test_carry_wrap();
    test_logic_store();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
